// File: rtl/branch_resolve.sv
// branch_resolve: execute-stage branch decision and front-end redirect/flush.
// Decides bne/blt/jump from the comparator flags. On a taken acceptance it
// emits a one-cycle registered redirect and holds flush for FLUSH_CYCLES
// cycles, refusing new instructions until the flush window has elapsed.
// Optional feature: define BRANCH_STATS_EN to add the 16-bit taken_count_o
// counter of taken acceptances, wrapping at 0xFFFF.
//
// state | meaning
// IDLE  | ready for a branch-class instruction (unless stalled)
// FLUSH | redirect issued, younger IF/ID being squashed; counter runs down
module branch_resolve #(
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clock_i,
  input  logic            reset_n_i,
  input  logic            in_valid_i,
  input  logic [1:0]      br_type_i,
  input  logic            cmp_eq_i,
  input  logic            cmp_gt_i,
  input  logic [PC_W-1:0] pc_plus1_i,
  input  logic [PC_W-1:0] target_i,
  input  logic            stall_i,
  output logic            in_ready_o,
  output logic            redirect_o,
  output logic [PC_W-1:0] redirect_pc_o,
  output logic            flush_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]     taken_count_o
`endif
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BNE  = 2'b01;
  localparam logic [1:0] BR_BLT  = 2'b10;
  localparam logic [1:0] BR_JUMP = 2'b11;

  // The counter only needs to cover 1..15.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            redirect_q, redirect_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic            taken;
  logic            accept;

  // The sequential successor is not needed: not-taken simply falls through.
  logic unused_pc_plus1;
  assign unused_pc_plus1 = ^pc_plus1_i;

  // Branch decision from the signed comparator flags (rd vs rs).
  always_comb begin
    taken = 1'b0;
    case (br_type_i)
      BR_NONE: taken = 1'b0;
      BR_BNE:  taken = !cmp_eq_i;
      BR_BLT:  taken = !cmp_eq_i && !cmp_gt_i;
      BR_JUMP: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign in_ready_o = (state_q == IDLE) && !stall_i;
  assign accept     = in_valid_i && in_ready_o;

  // Next-state: launch redirect/flush on a taken acceptance, run the flush down.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (accept && taken) begin
          state_d       = FLUSH;
          cnt_d         = FLUSH_LOAD;
          redirect_d    = 1'b1;
          redirect_pc_d = target_i;
        end
      end
      FLUSH: begin
        // Runs independently of stall so the squash window is fixed length.
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, counter and redirect registers; reset aborts any flush in progress.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;
  // FLUSH lasts exactly FLUSH_CYCLES cycles and begins with the redirect cycle.
  assign flush_o       = (state_q == FLUSH);

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_count_q, taken_count_d;

  // Taken-acceptance counter, free-running wrap.
  always_comb begin
    taken_count_d = taken_count_q;
    if (accept && taken) taken_count_d = taken_count_q + 16'd1;
  end

  // Statistics register.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) taken_count_q <= 16'd0;
    else            taken_count_q <= taken_count_d;
  end

  assign taken_count_o = taken_count_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed scenarios then random traffic, checked
// against a cycle-level behavioural model (remaining-flush count, last target).
module tb_branch_resolve;

  localparam int PC_W = 32;
  localparam int FC   = 2;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            in_valid;
  logic [1:0]      br_type;
  logic            cmp_eq;
  logic            cmp_gt;
  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] target;
  logic            stall;
  logic            in_ready;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            flush;
`ifdef BRANCH_STATS_EN
  logic [15:0]     taken_count;
`endif

  branch_resolve #(.PC_W(PC_W), .FLUSH_CYCLES(FC)) dut (
    .clock_i      (clock),
    .reset_n_i    (reset_n),
    .in_valid_i   (in_valid),
    .br_type_i    (br_type),
    .cmp_eq_i     (cmp_eq),
    .cmp_gt_i     (cmp_gt),
    .pc_plus1_i   (pc_plus1),
    .target_i     (target),
    .stall_i      (stall),
    .in_ready_o   (in_ready),
    .redirect_o   (redirect),
    .redirect_pc_o(redirect_pc),
    .flush_o      (flush)
`ifdef BRANCH_STATS_EN
    ,
    .taken_count_o(taken_count)
`endif
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  int              m_flush_rem = 0;
  bit              m_redirect  = 1'b0;
  logic [PC_W-1:0] m_pc        = '0;
  int              m_count     = 0;
  int              cyc         = 0;
  int              redir_cycles[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit model_taken(input logic [1:0] bt, input logic eq, input logic gt);
    // rd < rs means neither equal nor greater.
    if (bt == 2'b11) return 1'b1;
    if (bt == 2'b01) return !eq;
    if (bt == 2'b10) return !eq && !gt;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_flush_rem = 0;
    m_redirect  = 1'b0;
    m_pc        = '0;
    m_count     = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, m_redirect});
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, (m_flush_rem > 0)});
    chk({tag, ".redirect_pc"}, redirect_pc, m_pc);
`ifdef BRANCH_STATS_EN
    chk({tag, ".taken_count"}, {16'd0, taken_count}, 32'(m_count & 16'hFFFF));
`endif
  endtask

  // One clock: drive at negedge, check in_ready, clock, then check outputs.
  task automatic cycle(input string tag, input logic v, input logic [1:0] bt,
                       input logic eq, input logic gt, input logic [PC_W-1:0] tgt,
                       input logic st);
    bit exp_ready;
    bit acc;
    in_valid = v;
    br_type  = bt;
    cmp_eq   = eq;
    cmp_gt   = gt;
    target   = tgt;
    pc_plus1 = tgt + 32'd1;
    stall    = st;
    #1;
    exp_ready = (m_flush_rem == 0) && !st;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_ready});
    acc = v && exp_ready;
    @(posedge clock);
    cyc++;
    if (acc && model_taken(bt, eq, gt)) begin
      m_redirect  = 1'b1;
      m_pc        = tgt;
      m_flush_rem = FC;
      m_count++;
    end else begin
      m_redirect = 1'b0;
      if (m_flush_rem > 0) m_flush_rem--;
    end
    @(negedge clock);
    if (redirect === 1'b1) redir_cycles.push_back(cyc);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    br_type  = 2'b00;
    cmp_eq   = 1'b0;
    cmp_gt   = 1'b0;
    pc_plus1 = '0;
    target   = '0;
    stall    = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check_outputs("reset");
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    reset_n = 1'b1;

    // Taken bne straight after reset: redirect 1 cycle, flush FC cycles.
    cycle("bne_taken", 1'b1, 2'b01, 1'b0, 1'b0, 32'h100, 1'b0);
    chk("bne_taken.pc", redirect_pc, 32'h100);
    idle("bne_after", 3);

    // Not-taken variants leave everything quiet.
    cycle("blt_gt", 1'b1, 2'b10, 1'b0, 1'b1, 32'h200, 1'b0);
    cycle("blt_eq", 1'b1, 2'b10, 1'b1, 1'b0, 32'h204, 1'b0);
    cycle("bne_eq", 1'b1, 2'b01, 1'b1, 1'b0, 32'h208, 1'b0);
    cycle("none",   1'b1, 2'b00, 1'b0, 1'b0, 32'h20C, 1'b0);
    // Taken blt (rd < rs).
    cycle("blt_lt", 1'b1, 2'b10, 1'b0, 1'b0, 32'h300, 1'b0);
    idle("blt_after", 3);

    // Jump held under stall: no response until stall drops.
    for (int i = 0; i < 3; i++) cycle("jmp_stall", 1'b1, 2'b11, 1'b0, 1'b0, 32'h4, 1'b1);
    cycle("jmp_go", 1'b1, 2'b11, 1'b0, 1'b0, 32'h4, 1'b0);
    chk("jmp_go.pc", redirect_pc, 32'h4);
    idle("jmp_after", 3);

    // Back-to-back jumps: second accepted FC+1 cycles after the first.
    redir_cycles.delete();
    cycle("b2b_0", 1'b1, 2'b11, 1'b0, 1'b0, 32'h10, 1'b0);
    for (int i = 0; i < FC; i++) cycle("b2b_wait", 1'b1, 2'b11, 1'b0, 1'b0, 32'h20, 1'b0);
    cycle("b2b_1", 1'b1, 2'b11, 1'b0, 1'b0, 32'h20, 1'b0);
    chk("b2b.pc", redirect_pc, 32'h20);
    chk("b2b.pulses", 32'(redir_cycles.size()), 32'd2);
    if (redir_cycles.size() == 2)
      chk("b2b.gap", 32'(redir_cycles[1] - redir_cycles[0]), 32'(FC + 1));
    idle("b2b_after", 3);

    // Reset during the first flush cycle aborts the flush at once.
    cycle("rst_jmp", 1'b1, 2'b11, 1'b0, 1'b0, 32'h40, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_mid");
    chk("rst_mid.in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    idle("rst_after", 4);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            32'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    idle("final", 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
